vc_pop_scheduler: RTL and testbench
===================================

# vc_pop_scheduler

Pop scheduler and router between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1). It decides each cycle which VC FIFO to pop, applying VC0 priority with a VC1 anti-starvation limit and destination back-pressure. It routes the returned word to D0 or D1 by its destination bit, and keeps push counters and an idle flag for the link layer.

## Interface
Parameters:
- DATA_W, 6, word width of VC and D FIFOs
- DEST_BIT, 4, bit of the word selecting destination (0 → D0, 1 → D1)
- VC0_BURST, 4, max consecutive VC0 grants while VC1 is non-empty (≥1)
- CNT_W, 16, width of push counters

Ports:
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset
- enable  in  1  permits new pops; in-flight words always complete
- VC0_empty, VC1_empty  in  1  VC FIFO empty flags
- VC0_data, VC1_data  in  DATA_W  VC FIFO read data, valid the cycle after pop
- almost_full_fifo_D0, almost_full_fifo_D1  in  1  destination almost-full
- full_fifo_D0, full_fifo_D1  in  1  destination full
- VC0_pop, VC1_pop  out  1  combinational pop requests, never both high
- D0_push, D1_push  out  1  registered push strobes, never both high
- D0_data, D1_data  out  DATA_W  registered push data
- drop_err  out  1  sticky: a word was dropped on a full destination
- cnt_D0, cnt_D1  out  CNT_W  words pushed to D0 / D1, wrapping
- idle  out  1  registered: both VCs empty and nothing in flight

## Operation
- Eligible(t) = enable & !almost_full_fifo_D0 & !almost_full_fifo_D1 & !reset. Both D flags gate because the destination is unknown before the pop.
- Grant state machine, state = last grant: IDLE, G0, G1. Reset → IDLE.
  - Not eligible, or both VCs empty → IDLE, no pop.
  - VC0 non-empty, and (VC1 empty or burst_cnt < VC0_BURST) → pop VC0, state G0.
  - Otherwise VC1 non-empty → pop VC1, state G1.
- burst_cnt: increments on a VC0 grant while VC1 is non-empty, saturating at VC0_BURST. Clears on a VC1 grant or whenever VC1_empty=1.
- Pipeline:
  - Stage 1 registers pop_d and sel_d (which VC).
  - Stage 2 samples the selected VC*_data. DEST_BIT=0 loads D0_data and pushes D0; DEST_BIT=1 loads D1_data and pushes D1.
- If the chosen destination's full flag is high at stage 2: suppress the push, discard the word, set drop_err (held until reset). Counters do not increment.
- cnt_Dx increments on each Dx_push and wraps from 2^CNT_W−1 to 0.
- idle = VC0_empty & VC1_empty & !pop_d & !(any pop this cycle), registered.

## Timing
- Pop at cycle t → data sampled at t+1 → Dx_push/Dx_data valid at t+2. Latency is 2 cycles; throughput is 1 word/cycle.
- At most 2 words in flight. Destination almost_full must assert with ≥3 free entries; then full at stage 2 occurs only on a protocol violation.
- An empty flag seen high in cycle t blocks the pop that same cycle. A pop on the last word is legal; empty updates at t+1.
- Dropping enable or raising almost_full stops new pops the same cycle. Words already popped still push.
- Reset values: all pops and pushes 0, D*_data 0, counters 0, drop_err 0, idle 0, burst_cnt 0, state IDLE, pipeline valid bits 0.
- Reset mid-operation: in-flight words are discarded with no push. The first pop is possible the first cycle reset is low.

## Structure
- Shared package: DATA_W, DEST_BIT, grant state encoding (IDLE/G0/G1), CNT_W.
- One sub-module, vc_route_stage: stage-1/2 registers, destination decode, full check, drop_err, counters. The top holds the grant FSM and burst counter.

## Test plan
- Reset, then VC0 holds 3 words with dest bits 0,1,0 and VC1 is empty → VC0_pop at t, t+1, t+2. Pushes are D0, D1, D0 at t+2 to t+4; cnt_D0=2, cnt_D1=1; idle rises afterwards.
- Both VCs continuously non-empty, VC0_BURST=4 → grant pattern 0,0,0,0,1,0,0,0,0,1…; no cycle has both pops.
- almost_full_fifo_D1 held high for 5 cycles mid-stream → no pops during those cycles, the 2 in-flight words still push, and streaming resumes the cycle after deassertion.
- full_fifo_D0 forced high when a D0-bound word reaches stage 2 → D0_push=0, cnt_D0 unchanged, drop_err=1 until reset.
- Reset asserted one cycle after a pop → no push follows, all outputs 0 the next cycle.
- Preload cnt_D0 near wrap by streaming 65 536 D0 words → cnt_D0 returns to 0.

Source files
------------

// File: rtl/vc_pop_scheduler_pkg.sv
// vc_pop_scheduler_pkg
// Shared definitions for the VC pop scheduler slice: default word width,
// destination-select bit, VC0 burst limit, push counter width and the
// grant state encoding used by the top-level scheduler.
package vc_pop_scheduler_pkg;

    localparam int DATA_W    = 6;
    localparam int DEST_BIT  = 4;
    localparam int VC0_BURST = 4;
    localparam int CNT_W     = 16;

    // The grant state records which VC (if any) was popped last cycle.
    typedef enum logic [1:0] {
        GRANT_IDLE = 2'd0,
        GRANT_G0   = 2'd1,
        GRANT_G1   = 2'd2
    } grant_state_t;

endpackage

// File: rtl/vc_pop_scheduler_route_stage.sv
// vc_route_stage
// Two-stage routing pipeline behind the pop scheduler. Stage 1 remembers
// that a pop happened and which VC it came from; stage 2 picks up the word
// the VC FIFO returns, decodes its destination bit and pushes it into D0 or
// D1, or drops it if that destination is full. Also keeps the sticky drop
// flag and the wrapping per-destination push counters.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   vc0_pop, vc1_pop      pop requests issued by the scheduler this cycle
//   VC0_data, VC1_data    VC FIFO read data (valid the cycle after a pop)
//   full_fifo_D0/D1       destination full flags
//   D0_push, D1_push      registered push strobes
//   D0_data, D1_data      registered push data
//   drop_err              sticky: a word was discarded on a full destination
//   cnt_D0, cnt_D1        wrapping push counters
module vc_route_stage #(
    parameter int DATA_W   = vc_pop_scheduler_pkg::DATA_W,
    parameter int DEST_BIT = vc_pop_scheduler_pkg::DEST_BIT,
    parameter int CNT_W    = vc_pop_scheduler_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vc0_pop,
    input  logic              vc1_pop,
    input  logic [DATA_W-1:0] VC0_data,
    input  logic [DATA_W-1:0] VC1_data,
    input  logic              full_fifo_D0,
    input  logic              full_fifo_D1,
    output logic              D0_push,
    output logic              D1_push,
    output logic [DATA_W-1:0] D0_data,
    output logic [DATA_W-1:0] D1_data,
    output logic              drop_err,
    output logic [CNT_W-1:0]  cnt_D0,
    output logic [CNT_W-1:0]  cnt_D1
);
    import vc_pop_scheduler_pkg::*;

    logic              pop_d;
    logic              sel_d;
    logic [DATA_W-1:0] word;
    logic              to_d1;
    logic              push0_next;
    logic              push1_next;
    logic              drop_next;

    // Stage 1: the FIFO returns data one cycle after the pop, so remember
    // that a word is on its way and which VC will be presenting it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pop_d <= 1'b0;
            sel_d <= 1'b0;
        end else begin
            pop_d <= vc0_pop | vc1_pop;
            sel_d <= vc1_pop;
        end
    end

    // Destination decode on the returned word. A word is pushed only if its
    // destination has room; otherwise it is dropped and flagged.
    always_comb begin
        word       = sel_d ? VC1_data : VC0_data;
        to_d1      = word[DEST_BIT];
        push0_next = pop_d & ~to_d1 & ~full_fifo_D0;
        push1_next = pop_d &  to_d1 & ~full_fifo_D1;
        drop_next  = pop_d & ((~to_d1 & full_fifo_D0) | (to_d1 & full_fifo_D1));
    end

    // Stage 2: register the push strobes and data. Data registers only load
    // on an actual push so a dropped word never appears on the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            D0_push  <= 1'b0;
            D1_push  <= 1'b0;
            D0_data  <= '0;
            D1_data  <= '0;
            drop_err <= 1'b0;
        end else begin
            D0_push <= push0_next;
            D1_push <= push1_next;
            if (push0_next) begin
                D0_data <= word;
            end
            if (push1_next) begin
                D1_data <= word;
            end
            if (drop_next) begin
                drop_err <= 1'b1;
            end
        end
    end

    // Push counters advance once per visible push strobe and simply wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_D0 <= '0;
            cnt_D1 <= '0;
        end else begin
            cnt_D0 <= cnt_D0 + CNT_W'(D0_push);
            cnt_D1 <= cnt_D1 + CNT_W'(D1_push);
        end
    end

endmodule

// File: rtl/vc_pop_scheduler.sv
// vc_pop_scheduler
// Decides each cycle which virtual-channel FIFO to pop (VC0 preferred, with
// a limit on consecutive VC0 grants while VC1 is waiting), holds pops while
// disabled or while either destination is almost full, and hands the popped
// words to the routing pipeline that pushes them into D0 or D1.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   enable                     permits new pops (in-flight words still finish)
//   VC0_empty, VC1_empty       VC FIFO empty flags
//   VC0_data, VC1_data         VC FIFO read data
//   almost_full_fifo_D0/D1     destination almost-full flags (gate new pops)
//   full_fifo_D0/D1            destination full flags (cause drops)
//   VC0_pop, VC1_pop           combinational pop requests, mutually exclusive
//   D0_push, D1_push           registered push strobes
//   D0_data, D1_data           registered push data
//   drop_err                   sticky drop indication
//   cnt_D0, cnt_D1             wrapping push counters
//   idle                       registered: no work queued and nothing in flight
module vc_pop_scheduler #(
    parameter int DATA_W    = vc_pop_scheduler_pkg::DATA_W,
    parameter int DEST_BIT  = vc_pop_scheduler_pkg::DEST_BIT,
    parameter int VC0_BURST = vc_pop_scheduler_pkg::VC0_BURST,
    parameter int CNT_W     = vc_pop_scheduler_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              VC0_empty,
    input  logic              VC1_empty,
    input  logic [DATA_W-1:0] VC0_data,
    input  logic [DATA_W-1:0] VC1_data,
    input  logic              almost_full_fifo_D0,
    input  logic              almost_full_fifo_D1,
    input  logic              full_fifo_D0,
    input  logic              full_fifo_D1,
    output logic              VC0_pop,
    output logic              VC1_pop,
    output logic              D0_push,
    output logic              D1_push,
    output logic [DATA_W-1:0] D0_data,
    output logic [DATA_W-1:0] D1_data,
    output logic              drop_err,
    output logic [CNT_W-1:0]  cnt_D0,
    output logic [CNT_W-1:0]  cnt_D1,
    output logic              idle
);
    import vc_pop_scheduler_pkg::*;

    localparam int                 BURST_W   = $clog2(VC0_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(VC0_BURST);

    grant_state_t       state;
    logic [BURST_W-1:0] burst_cnt;
    logic               eligible;
    logic               grant_vc0;
    logic               grant_vc1;

    // Grant decision. Both almost-full flags gate because the destination of
    // a word is unknown until it comes back from the FIFO. VC0 wins unless
    // VC1 is waiting and VC0 has already used up its burst allowance.
    always_comb begin
        eligible  = enable & ~almost_full_fifo_D0 & ~almost_full_fifo_D1 & ~reset;
        grant_vc0 = eligible & ~VC0_empty & (VC1_empty | (burst_cnt < BURST_MAX));
        grant_vc1 = eligible & ~VC1_empty & ~grant_vc0;
    end

    assign VC0_pop = grant_vc0;
    assign VC1_pop = grant_vc1;

    // Grant state machine (state = last grant) and the VC0 burst counter.
    // The counter only measures VC0 grants made while VC1 is kept waiting,
    // so it restarts whenever VC1 is served or has nothing to offer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= GRANT_IDLE;
            burst_cnt <= '0;
        end else begin
            if (grant_vc0) begin
                state <= GRANT_G0;
            end else if (grant_vc1) begin
                state <= GRANT_G1;
            end else begin
                state <= GRANT_IDLE;
            end

            if (VC1_empty || grant_vc1) begin
                burst_cnt <= '0;
            end else if (grant_vc0 && (burst_cnt < BURST_MAX)) begin
                burst_cnt <= burst_cnt + BURST_W'(1);
            end
        end
    end

    // Idle flag. A non-IDLE grant state means a word popped last cycle is
    // still travelling through stage 1, so the block is not idle yet.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle <= 1'b0;
        end else begin
            idle <= VC0_empty & VC1_empty & (state == GRANT_IDLE)
                    & ~(grant_vc0 | grant_vc1);
        end
    end

    vc_route_stage #(
        .DATA_W  (DATA_W),
        .DEST_BIT(DEST_BIT),
        .CNT_W   (CNT_W)
    ) u_route (
        .clk         (clk),
        .reset       (reset),
        .vc0_pop     (grant_vc0),
        .vc1_pop     (grant_vc1),
        .VC0_data    (VC0_data),
        .VC1_data    (VC1_data),
        .full_fifo_D0(full_fifo_D0),
        .full_fifo_D1(full_fifo_D1),
        .D0_push     (D0_push),
        .D1_push     (D1_push),
        .D0_data     (D0_data),
        .D1_data     (D1_data),
        .drop_err    (drop_err),
        .cnt_D0      (cnt_D0),
        .cnt_D1      (cnt_D1)
    );

endmodule

// File: tb/tb_vc_pop_scheduler.sv
// tb_vc_pop_scheduler
// Self-checking bench: models the two VC FIFOs as queues, predicts every
// output from the scheduling/routing rules, and compares every cycle.
module tb_vc_pop_scheduler;

    localparam int DW    = 6;
    localparam int BURST = 4;

    logic          clk = 1'b0;
    logic          reset, enable;
    logic          VC0_empty, VC1_empty;
    logic [DW-1:0] VC0_data, VC1_data;
    logic          almost_full_fifo_D0, almost_full_fifo_D1;
    logic          full_fifo_D0, full_fifo_D1;
    logic          VC0_pop, VC1_pop, D0_push, D1_push;
    logic [DW-1:0] D0_data, D1_data;
    logic          drop_err, idle;
    logic [15:0]   cnt_D0, cnt_D1;

    always #5 clk = ~clk;

    vc_pop_scheduler dut (
        .clk(clk), .reset(reset), .enable(enable),
        .VC0_empty(VC0_empty), .VC1_empty(VC1_empty),
        .VC0_data(VC0_data), .VC1_data(VC1_data),
        .almost_full_fifo_D0(almost_full_fifo_D0), .almost_full_fifo_D1(almost_full_fifo_D1),
        .full_fifo_D0(full_fifo_D0), .full_fifo_D1(full_fifo_D1),
        .VC0_pop(VC0_pop), .VC1_pop(VC1_pop),
        .D0_push(D0_push), .D1_push(D1_push),
        .D0_data(D0_data), .D1_data(D1_data),
        .drop_err(drop_err), .cnt_D0(cnt_D0), .cnt_D1(cnt_D1), .idle(idle)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    bit c_reset, c_enable, c_af0, c_af1, c_f0, c_f1;
    bit refill_mode = 0;

    // Behavioural model state: what the outputs must be this cycle.
    bit            m_push0, m_push1, m_drop, m_idle, m_s1_valid;
    logic [DW-1:0] m_d0, m_d1, m_s1_word;
    int            m_cnt0, m_cnt1, m_burst;

    bit last_p0, last_p1;
    int push_seen;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic setControls(input bit r, input bit en, input bit a0, input bit a1,
                               input bit f0, input bit f1);
        c_reset = r; c_enable = en; c_af0 = a0; c_af1 = a1; c_f0 = f0; c_f1 = f1;
    endtask

    task automatic applyStimulus();
        reset               = c_reset;
        enable              = c_enable;
        almost_full_fifo_D0 = c_af0;
        almost_full_fifo_D1 = c_af1;
        full_fifo_D0        = c_f0;
        full_fifo_D1        = c_f1;
        VC0_empty           = (q0.size() == 0);
        VC1_empty           = (q1.size() == 0);
    endtask

    // One full clock cycle: drive, predict and compare, then advance the
    // FIFO environment and the model across the rising edge.
    task automatic runCycle();
        bit            elig, e0, e1, emp0, emp1, p0, p1, np0, np1;
        logic [DW-1:0] f0w, f1w;
        applyStimulus();
        #1;
        emp0 = (q0.size() == 0);
        emp1 = (q1.size() == 0);
        elig = c_enable && !c_af0 && !c_af1 && !c_reset;
        e0   = elig && !emp0 && (emp1 || m_burst < BURST);
        e1   = elig && !emp1 && !e0;
        checkOutput("VC0_pop", 32'(VC0_pop), 32'(e0));
        checkOutput("VC1_pop", 32'(VC1_pop), 32'(e1));
        checkOutput("pop_exclusive", 32'(VC0_pop & VC1_pop), 32'd0);
        checkOutput("D0_push", 32'(D0_push), 32'(m_push0));
        checkOutput("D1_push", 32'(D1_push), 32'(m_push1));
        checkOutput("D0_data", 32'(D0_data), 32'(m_d0));
        checkOutput("D1_data", 32'(D1_data), 32'(m_d1));
        checkOutput("drop_err", 32'(drop_err), 32'(m_drop));
        checkOutput("cnt_D0", 32'(cnt_D0), 32'(m_cnt0));
        checkOutput("cnt_D1", 32'(cnt_D1), 32'(m_cnt1));
        checkOutput("idle", 32'(idle), 32'(m_idle));
        p0 = VC0_pop;
        p1 = VC1_pop;
        last_p0 = p0;
        last_p1 = p1;
        if (D0_push || D1_push) push_seen++;
        f0w = emp0 ? '0 : q0[0];
        f1w = emp1 ? '0 : q1[0];
        @(posedge clk);
        #1;
        if (c_reset) begin
            m_push0 = 0; m_push1 = 0; m_drop = 0; m_idle = 0; m_s1_valid = 0;
            m_d0 = '0; m_d1 = '0; m_s1_word = '0;
            m_cnt0 = 0; m_cnt1 = 0; m_burst = 0;
        end else begin
            m_cnt0 = (m_cnt0 + int'(m_push0)) % 65536;
            m_cnt1 = (m_cnt1 + int'(m_push1)) % 65536;
            np0 = 0;
            np1 = 0;
            if (m_s1_valid) begin
                if (m_s1_word[4]) begin
                    if (c_f1) m_drop = 1;
                    else begin np1 = 1; m_d1 = m_s1_word; end
                end else begin
                    if (c_f0) m_drop = 1;
                    else begin np0 = 1; m_d0 = m_s1_word; end
                end
            end
            m_push0    = np0;
            m_push1    = np1;
            m_idle     = emp0 && emp1 && !m_s1_valid && !(e0 || e1);
            m_s1_valid = e0 || e1;
            m_s1_word  = e0 ? f0w : f1w;
            if (emp1 || e1) m_burst = 0;
            else if (e0 && m_burst < BURST) m_burst++;
        end
        if (p0 && q0.size() > 0) VC0_data = q0.pop_front();
        else VC0_data = DW'($urandom);
        if (p1 && q1.size() > 0) VC1_data = q1.pop_front();
        else VC1_data = DW'($urandom);
        if (refill_mode) begin
            if (q0.size() < 6 && $urandom_range(0, 9) < 6) q0.push_back(DW'($urandom));
            if (q1.size() < 6 && $urandom_range(0, 9) < 4) q1.push_back(DW'($urandom));
        end
        @(negedge clk);
    endtask

    task automatic resetCycle();
        q0.delete();
        q1.delete();
        setControls(1, 1, 0, 0, 0, 0);
        runCycle();
        setControls(0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        VC0_data = '0;
        VC1_data = '0;
        setControls(1, 0, 0, 0, 0, 0);
        applyStimulus();
        @(posedge clk);
        @(negedge clk);
        runCycle();
        checkOutput("reset_idle", 32'(idle), 32'd0);
        checkOutput("reset_cnt_D0", 32'(cnt_D0), 32'd0);
        checkOutput("reset_drop", 32'(drop_err), 32'd0);

        // Three VC0 words routed D0, D1, D0.
        setControls(0, 1, 0, 0, 0, 0);
        q0.push_back(6'h01);
        q0.push_back(6'h11);
        q0.push_back(6'h02);
        for (int i = 0; i < 6; i++) runCycle();
        checkOutput("seq_cnt_D0", 32'(cnt_D0), 32'd2);
        checkOutput("seq_cnt_D1", 32'(cnt_D1), 32'd1);
        checkOutput("seq_D0_data", 32'(D0_data), 32'h02);
        checkOutput("seq_D1_data", 32'(D1_data), 32'h11);
        checkOutput("seq_idle", 32'(idle), 32'd1);

        // Both VCs busy: four VC0 grants then one VC1 grant, repeating.
        resetCycle();
        for (int i = 0; i < 20; i++) begin
            q0.push_back(DW'($urandom));
            q1.push_back(DW'($urandom));
        end
        for (int i = 0; i < 10; i++) begin
            runCycle();
            checkOutput("burst_vc1", 32'(last_p1), 32'((i % 5) == 4));
            checkOutput("burst_vc0", 32'(last_p0), 32'((i % 5) != 4));
        end

        // almost_full on D1 for five cycles in the middle of a VC0 stream.
        resetCycle();
        for (int i = 0; i < 20; i++) q0.push_back(DW'($urandom));
        for (int i = 0; i < 3; i++) runCycle();
        setControls(0, 1, 0, 1, 0, 0);
        push_seen = 0;
        for (int i = 0; i < 5; i++) runCycle();
        checkOutput("af_inflight_pushes", 32'(push_seen), 32'd2);
        setControls(0, 1, 0, 0, 0, 0);
        runCycle();
        checkOutput("af_resume", 32'(last_p0), 32'd1);

        // D0-bound word meets a full D0 at stage 2.
        resetCycle();
        q0.push_back(6'h05);
        runCycle();
        setControls(0, 1, 0, 0, 1, 0);
        runCycle();
        setControls(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) runCycle();
        checkOutput("drop_sticky", 32'(drop_err), 32'd1);
        checkOutput("drop_cnt_D0", 32'(cnt_D0), 32'd0);
        resetCycle();
        checkOutput("drop_cleared", 32'(drop_err), 32'd0);

        // Reset one cycle after a pop discards the in-flight word.
        q0.push_back(6'h07);
        runCycle();
        setControls(1, 1, 0, 0, 0, 0);
        runCycle();
        setControls(0, 1, 0, 0, 0, 0);
        q0.delete();
        runCycle();
        checkOutput("rst_mid_push", 32'(D0_push), 32'd0);
        checkOutput("rst_mid_cnt", 32'(cnt_D0), 32'd0);
        checkOutput("rst_mid_data", 32'(D0_data), 32'd0);

        // Randomized traffic with occasional back-pressure, drops and resets.
        refill_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            setControls($urandom_range(0, 99) < 1, $urandom_range(0, 9) < 9,
                        $urandom_range(0, 9) < 1, $urandom_range(0, 9) < 1,
                        $urandom_range(0, 19) < 1, $urandom_range(0, 19) < 1);
            runCycle();
        end
        refill_mode = 0;

        // Exactly 65536 D0-bound words wrap cnt_D0 back to zero.
        resetCycle();
        for (int i = 0; i < 65536; i++) q0.push_back(DW'($urandom_range(0, 63)) & 6'h2F);
        for (int i = 0; i < 65541; i++) runCycle();
        checkOutput("wrap_cnt_D0", 32'(cnt_D0), 32'd0);
        checkOutput("wrap_cnt_D1", 32'(cnt_D1), 32'd0);
        checkOutput("wrap_idle", 32'(idle), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
